axis_spp_framer: RTL and testbench

//  Frames a continuous sample stream into fixed-length packets of SPP beats ahead of the AXI wrapper's s_axis_data port.

---
 rtl/axis_spp_framer.sv | 85 ++++++++
 tb/tb_axis_spp_framer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_spp_framer.sv
// axis_spp_framer: frames a sample stream into SPP-beat packets with a latched per-packet tuser header
module axis_spp_framer #(
  parameter logic [7:0]  SR_SPP      = 8'd129,
  parameter int          WIDTH       = 32,
  parameter logic [15:0] DEFAULT_SPP = 16'd256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_tx_seqnum,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [15:0]      src_sid,
  input  logic [15:0]      next_dst_sid,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [127:0]     o_tuser
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t r_state, w_state_nxt;
  logic [15:0] r_cnt, r_spp_active, r_spp_pending;
  logic [11:0] r_seq;
  logic [63:0] r_hdr;
  logic r_cleared, r_tvalid, r_tlast;
  logic [WIDTH-1:0] r_tdata;
  logic [127:0] r_tuser;
  logic w_accept, w_idle, w_last, w_hold;
  logic [15:0] w_spp, w_spp_eff;
  logic [63:0] w_hdr;
  logic w_unused;
  assign i_tready = ~r_tvalid | o_tready;
  assign o_tvalid = r_tvalid;
  assign o_tlast = r_tlast;
  assign o_tdata = r_tdata;
  assign o_tuser = r_tuser;
  assign w_unused = ^set_data[31:16];
  always_comb begin
    w_accept = i_tvalid & i_tready;
    w_idle = r_state == IDLE;
    w_spp = w_idle ? r_spp_pending : r_spp_active;
    w_spp_eff = (w_spp == 16'd0) ? 16'd1 : w_spp;
    w_last = i_tlast | (r_cnt == w_spp_eff - 16'd1);
    w_hold = r_cleared & ~w_idle;
    w_hdr = w_idle ? {4'b0000, r_seq, 16'd0, src_sid, next_dst_sid} : r_hdr;
    w_state_nxt = w_accept ? (w_last ? IDLE : IN_PKT) : r_state;
  end
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_seq <= '0;
      r_hdr <= '0;
      r_cleared <= 1'b0;
      r_spp_active <= DEFAULT_SPP;
      r_spp_pending <= DEFAULT_SPP;
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_tdata <= '0;
      r_tuser <= '0;
    end else begin
      if (set_stb && set_addr == SR_SPP) r_spp_pending <= set_data[15:0];
      if (w_accept && w_idle) begin
        r_spp_active <= r_spp_pending;
        r_hdr <= w_hdr;
      end
      if (w_accept) begin
        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
        r_tdata <= i_tdata;
        r_tlast <= w_last;
        r_tuser <= {w_hdr, 64'd0};
      end
      r_tvalid <= w_accept | (r_tvalid & ~o_tready);
      r_cleared <= clear_tx_seqnum | (r_cleared & ~(w_accept & w_idle));
      r_seq <= clear_tx_seqnum ? 12'd0 : (w_accept & w_last & ~w_hold) ? r_seq + 12'd1 : r_seq;
    end
  end
endmodule

// File: tb/tb_axis_spp_framer.sv
// tb_axis_spp_framer: table-driven and randomized checks of axis_spp_framer against a packet-level model
module tb_axis_spp_framer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_tx_seqnum = 1'b0;
  logic set_stb = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic [15:0] src_sid = 16'h1234;
  logic [15:0] next_dst_sid = 16'h5678;
  logic [31:0] i_tdata = '0;
  logic i_tlast = 1'b0;
  logic i_tvalid = 1'b0;
  logic i_tready;
  logic [31:0] o_tdata;
  logic o_tlast, o_tvalid;
  logic o_tready = 1'b1;
  logic [127:0] o_tuser;
  always #5 clk = ~clk;
  axis_spp_framer dut (
    .clk(clk), .reset(reset), .clear_tx_seqnum(clear_tx_seqnum),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .src_sid(src_sid), .next_dst_sid(next_dst_sid),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser)
  );
  int n_vec = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct packed {logic [31:0] d; logic l; logic [63:0] h;} beat_t;
  beat_t q[$];
  beat_t e;
  int m_left = 0;
  logic [11:0] m_prev = '0;
  logic m_clr = 1'b1;
  logic [15:0] m_pend = 16'd256;
  logic [63:0] m_hdr = '0;
  logic m_l;
  int n_lasts = 0;
  int stalls = 0;
  logic p_stall = 1'b0;
  logic [160:0] p_out = '0;
  logic rnd_ready = 1'b0;
  logic tready_fix = 1'b1;
  always @(posedge clk) begin
    #1;
    o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : tready_fix;
  end
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_left = 0;
      m_prev = '0;
      m_clr = 1'b1;
      m_pend = 16'd256;
      p_stall = 1'b0;
    end else begin
      if (p_stall) check("stall_hold", {o_tvalid, o_tdata, o_tlast, o_tuser}, {1'b1, p_out});
      if (o_tvalid && o_tready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL out_beat: got unexpected beat %h expected none", o_tdata);
        end else begin
          e = q.pop_front();
          check("out_beat", {1'b1, o_tdata, o_tlast, o_tuser}, {1'b1, e.d, e.l, e.h, 64'd0});
          if (o_tlast) n_lasts++;
        end
      end
      if (i_tvalid && i_tready) begin
        if (m_left == 0) begin
          m_left = (m_pend == 16'd0) ? 1 : int'(m_pend);
          m_prev = m_clr ? 12'd0 : m_prev + 12'd1;
          m_clr = 1'b0;
          m_hdr = {4'b0000, m_prev, 16'd0, src_sid, next_dst_sid};
        end
        m_l = i_tlast || m_left == 1;
        q.push_back('{i_tdata, m_l, m_hdr});
        m_left = m_l ? 0 : m_left - 1;
      end
      if (clear_tx_seqnum) m_clr = 1'b1;
      if (set_stb && set_addr == 8'd129) m_pend = set_data[15:0];
      p_stall = o_tvalid && !o_tready;
      p_out = {o_tdata, o_tlast, o_tuser};
    end
  end
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_stb = 1'b0;
      clear_tx_seqnum = 1'b0;
    end
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    i_tvalid = 1'b1;
    i_tdata = d;
    i_tlast = l;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      set_stb = 1'b0;
      clear_tx_seqnum = 1'b0;
      if (!acc) stalls++;
      guard++;
    end
    if (!acc) check("send_timeout", 162'(acc), 162'(1));
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask
  task automatic write_spp(input logic [15:0] v);
    set_stb = 1'b1;
    set_addr = 8'd129;
    set_data = {16'hdead, v};
    cycles(1);
  endtask
  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || o_tvalid) && g < 2000) begin
      cycles(1);
      g++;
    end
    check("drain", {161'(q.size()), o_tvalid}, 162'(0));
  endtask
  typedef struct {logic [15:0] spp; int beats; int exp_lasts;} vec_t;
  vec_t vecs[6];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, st;
    vecs[0] = '{16'd4, 12, 3};
    vecs[1] = '{16'd1, 5, 5};
    vecs[2] = '{16'd0, 4, 4};
    vecs[3] = '{16'd3, 9, 3};
    vecs[4] = '{16'd2, 6, 3};
    vecs[5] = '{16'd5, 10, 2};
    cycles(3);
    check("reset_outputs", {o_tvalid, o_tlast, o_tdata, o_tuser}, 162'(0));
    check("reset_tready", 162'(i_tready), 162'(1));
    reset = 1'b0;
    cycles(1);
    for (int i = 0; i < 6; i++) begin
      write_spp(vecs[i].spp);
      base = n_lasts;
      st = stalls;
      for (int b = 0; b < vecs[i].beats; b++) send($urandom, 1'b0);
      drain();
      check("pkt_count", 162'(n_lasts - base), 162'(vecs[i].exp_lasts));
      check("throughput_stalls", 162'(stalls - st), 162'(0));
    end
    write_spp(16'd4);
    base = n_lasts;
    send(32'ha1, 1'b0);
    send(32'ha2, 1'b1);
    for (int b = 0; b < 4; b++) send(32'hb0 + 32'(b), 1'b0);
    drain();
    check("short_pkt_count", 162'(n_lasts - base), 162'(2));
    base = n_lasts;
    send(32'hc1, 1'b0);
    set_stb = 1'b1;
    set_addr = 8'd129;
    set_data = 32'd3;
    send(32'hc2, 1'b0);
    for (int b = 0; b < 5; b++) send(32'hc3 + 32'(b), 1'b0);
    drain();
    check("spp_change_count", 162'(n_lasts - base), 162'(2));
    rnd_ready = 1'b1;
    write_spp(16'd5);
    for (int b = 0; b < 300; b++) begin
      src_sid = 16'($urandom);
      next_dst_sid = 16'($urandom);
      if ($urandom_range(0, 3) == 0) cycles(1);
      send($urandom, $urandom_range(0, 7) == 0);
    end
    drain();
    rnd_ready = 1'b0;
    write_spp(16'd1);
    base = n_lasts;
    for (int b = 0; b < 4097; b++) send(32'(b), 1'b0);
    drain();
    check("wrap_pkt_count", 162'(n_lasts - base), 162'(4097));
    write_spp(16'd4);
    send(32'hd1, 1'b0);
    send(32'hd2, 1'b0);
    clear_tx_seqnum = 1'b1;
    cycles(1);
    send(32'hd3, 1'b0);
    send(32'hd4, 1'b0);
    for (int b = 0; b < 3; b++) send(32'he0 + 32'(b), 1'b0);
    clear_tx_seqnum = 1'b1;
    send(32'he3, 1'b0);
    for (int b = 0; b < 4; b++) send(32'hf0 + 32'(b), 1'b0);
    drain();
    write_spp(16'd0);
    base = n_lasts;
    for (int b = 0; b < 5; b++) send($urandom, 1'b0);
    drain();
    check("spp0_count", 162'(n_lasts - base), 162'(5));
    write_spp(16'd4);
    send(32'h11, 1'b0);
    send(32'h12, 1'b0);
    reset = 1'b1;
    cycles(1);
    check("midreset_outputs", {o_tvalid, o_tlast, o_tuser}, 162'(0));
    reset = 1'b0;
    cycles(1);
    base = n_lasts;
    for (int b = 0; b < 256; b++) send($urandom, 1'b0);
    drain();
    check("default_spp_count", 162'(n_lasts - base), 162'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
